// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit
// Bit-serial subtractor: resolves one bit of a - b - bin per clock through a
// single full-adder slice computing a + ~b + ~bin. Operands are captured on an
// accepted start, results are published on entry to DONE and held until the
// next DONE entry or reset. All outputs come straight from registers.

module serial_subtractor_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  // Holds the WIDTH-1 already-resolved bits; the last bit joins them directly
  // on the way into diff, so no slot is ever left unused.
  logic [WIDTH-2:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  // Full-adder slice inputs for the bit currently being resolved.
  logic             bit_x, bit_y, bit_c;
  logic             sum_bit, carry_out;
  logic [WIDTH-1:0] full_result;
  logic             accept;

  assign bit_x       = a_sr_q[0];
  assign bit_y       = ~b_sr_q[0];
  assign bit_c       = carry_q;
  assign sum_bit     = bit_x ^ bit_y ^ bit_c;
  assign carry_out   = (bit_x & bit_y) | (bit_x & bit_c) | (bit_y & bit_c);
  assign full_result = {sum_bit, res_q};
  assign accept      = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state, datapath and result-publish logic.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned; without these defaults the tool would infer latches.
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          // Subtraction as addition: a + ~b + 1 - bin, so the initial carry
          // into bit 0 is ~bin.
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = ~bin;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        res_d   = full_result[WIDTH-1:1];
        carry_d = carry_out;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish on the same edge the final bit resolves, so done and the
          // result appear together. A clear carry out means a borrow out.
          state_d = S_DONE;
          diff_d  = full_result;
          bout_d  = ~carry_out;
          zero_d  = (full_result == '0);
          ovf_d   = (a_msb_q != b_msb_q) && (full_result[WIDTH-1] != a_msb_q);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (!rst_n) begin
      // NOTE: the operand shift registers are reset too; they are ordinary
      // flops, not a RAM, and a defined zero state keeps a discarded partial
      // operation from leaving anything observable behind.
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Testbench for serial_subtractor_16bit: directed vectors with hand-computed
// results feed a scoreboard queue; a monitor on the falling edge checks
// busy/done timing every cycle, pops expected results on done and checks that
// the held outputs never change between done pulses.

module tb_serial_subtractor_16bit;

  localparam int W       = 16;
  localparam int LATENCY = 16;  // edges from the capturing edge to the DONE edge

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } vec_t;

  typedef struct {
    int           cyc;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         bout, zero, ovf;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic mon_en = 1'b0;

  vec_t vecs[14];
  exp_t sb[$];

  // Values the DUT outputs must hold outside done cycles.
  logic [W-1:0] hold_diff = '0;
  logic         hold_bout = 1'b0;
  logic         hold_zero = 1'b0;
  logic         hold_ovf  = 1'b0;

  serial_subtractor_16bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive operands with start high, wait n_edges rising edges (the last one
  // captures), then queue the expected result LATENCY edges later.
  task automatic issue(input int idx, input int n_edges, input bit keep_start);
    exp_t e;
    a     = vecs[idx].a;
    b     = vecs[idx].b;
    bin   = vecs[idx].bin;
    start = 1'b1;
    repeat (n_edges) @(posedge clk);
    #1;
    e.cyc  = cyc + LATENCY;
    e.diff = vecs[idx].diff;
    e.bout = vecs[idx].bout;
    e.zero = vecs[idx].zero;
    e.ovf  = vecs[idx].ovf;
    sb.push_back(e);
    if (!keep_start) start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle handshake and output checks against the scoreboard.
  initial begin
    exp_t head;
    logic exp_busy, exp_done;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (sb.size() > 0) begin
          head     = sb[0];
          exp_done = (cyc == head.cyc);
          exp_busy = (cyc >= head.cyc - LATENCY) && (cyc < head.cyc);
        end
        check("busy", {31'b0, busy}, {31'b0, exp_busy});
        check("done", {31'b0, done}, {31'b0, exp_done});
        if (busy && done) check("busy_and_done", 32'd1, 32'd0);
        if (exp_done) begin
          void'(sb.pop_front());
          hold_diff = head.diff;
          hold_bout = head.bout;
          hold_zero = head.zero;
          hold_ovf  = head.ovf;
        end
        check("diff", {16'b0, diff}, {16'b0, hold_diff});
        check("bout", {31'b0, bout}, {31'b0, hold_bout});
        check("zero", {31'b0, zero}, {31'b0, hold_zero});
        check("ovf",  {31'b0, ovf},  {31'b0, hold_ovf});
      end
    end
  end

  // Stimulus.
  initial begin
    //           a         b         bin   diff      bout  zero  ovf
    vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{16'h0F0F, 16'h00F0, 1'b0, 16'h0E1F, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h1111, 16'h2222, 1'b0, 16'hEEEF, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{16'h2222, 16'h1111, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{16'h4000, 16'hC000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    idle(2);
    mon_en = 1'b1;           // first checks see the reset state
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Isolated operations, including the borrow, zero and overflow corners.
    for (int i = 0; i <= 7; i++) begin
      issue(i, 1, 1'b0);
      idle(LATENCY + 3);
    end

    // Start pulses and operand changes while busy must be ignored.
    issue(8, 1, 1'b0);
    idle(2);
    a   = 16'hFFFF;
    b   = 16'hFFFF;
    bin = 1'b1;
    for (int k = 0; k < 8; k++) begin
      start = ~start;
      idle(1);
    end
    start = 1'b0;
    idle(LATENCY);

    // Reset in cycle 8 of an operation discards it; a fresh one completes.
    issue(9, 1, 1'b0);
    idle(6);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    hold_diff = '0;
    hold_bout = 1'b0;
    hold_zero = 1'b0;
    hold_ovf  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    issue(10, 1, 1'b0);
    idle(LATENCY + 3);

    // Start held high: three operations back to back, one per DONE cycle.
    issue(11, 1, 1'b1);
    issue(12, LATENCY + 1, 1'b1);
    issue(13, LATENCY + 1, 1'b0);

    // Drain with a bounded wait.
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    idle(3);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
